window_scan_ctrl: RTL
=====================

WINDOW_SCAN_CTRL -- requirements
Module: window_scan_ctrl

Interface
REQ-001 Parameters SHALL be: IMG_W, default 16, image width in pixels (>=3); IMG_H, default 16, image height in pixels (>=3); ADDR_W, default 16, pixel address width; COORD_W, default 8, window coordinate width.
REQ-002 Ports SHALL be, clock and reset first:
- clk  in  1  single clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-high
- start  in  1  one-cycle pulse that begins a frame scan
- mem_req  out  1  one-cycle read-request pulse to pixel memory
- mem_addr  out  ADDR_W  pixel address, valid with mem_req
- mem_rvalid  in  1  read data valid
- mem_rdata  in  8  read data
- start_read  out  1  one-cycle pixel-write strobe to the window buffer
- start_shift  out  1  one-cycle shift strobe to the window buffer
- shift_direc  out  2  00 full load, 01 shift left, 10 shift right, 11 shift down
- data_r  out  8  pixel to the window buffer
- shift_done  in  1  window buffer shift acknowledge
- window_valid  out  1  current 3x3 window is complete
- win_ack  in  1  downstream Sobel stage has consumed the window
- win_x, win_y  out  COORD_W each  top-left coordinate of the current window
- busy  out  1  scan in progress
- done  out  1  one-cycle pulse when the frame finishes

Function
REQ-003 Addressing SHALL be mem_addr = row*IMG_W + col, truncated to ADDR_W bits.
REQ-004 Scan order SHALL be serpentine: band 0 (win_y=0) moves right from win_x=0 to IMG_W-3; each following band moves in the opposite direction; total windows = (IMG_W-2)*(IMG_H-2).
REQ-005 States SHALL be IDLE, LOAD_REQ, LOAD_WAIT, EMIT, SHIFT, COL_REQ, COL_WAIT, FINISH.
REQ-006 IDLE: on start, the block SHALL clear win_x and win_y, set busy, and go to LOAD_REQ; start SHALL be ignored in all other states.
REQ-007 Full load (shift_direc=00) SHALL read 9 pixels in this order: (x..x+2, y), then (x..x+2, y+1), then (x..x+2, y+2).
REQ-008 At most one memory read SHALL be outstanding: mem_req pulses once in a *_REQ state, then the FSM waits in *_WAIT for mem_rvalid; mem_rvalid outside a WAIT state SHALL be ignored.
REQ-009 On mem_rvalid, data_r SHALL register mem_rdata and start_read SHALL pulse in the following cycle, with shift_direc held.
REQ-010 After the last pixel of a group, the FSM SHALL enter EMIT, asserting window_valid until win_ack is sampled high; window_valid SHALL deassert in the cycle after the ack.
REQ-011 Leaving EMIT: at band end (x=IMG_W-3 moving right, x=0 moving left), if y=IMG_H-3 the FSM SHALL go to FINISH; otherwise shift_direc SHALL be 11. Mid-band, shift_direc SHALL be 01 (moving right) or 10 (moving left).
REQ-012 SHIFT SHALL pulse start_shift for one cycle, then wait for shift_done, then update coordinates (01: x+1; 10: x-1; 11: y+1), then go to COL_REQ.
REQ-013 Column/row group SHALL be 3 reads: 01 -> (x+2, y..y+2); 10 -> (x, y..y+2); 11 -> (x..x+2, y+2), using post-update coordinates.
REQ-014 shift_direc SHALL stay stable from the start_shift pulse until the last start_read of its group.
REQ-015 FINISH SHALL pulse done for one cycle, clear busy, and return to IDLE.
REQ-016 win_ack while window_valid is low SHALL have no effect; start_read and start_shift SHALL never be asserted in the same cycle.

Reset
REQ-017 While rst is high the block SHALL be in IDLE, with every output at 0 (mem_req, mem_addr, start_read, start_shift, shift_direc, data_r, window_valid, win_x, win_y, busy, done).
REQ-018 Reset asserted mid-scan SHALL abandon the scan immediately; a mem_rvalid from the abandoned read SHALL be ignored after reset is released.

Verification
REQ-019 The bench SHALL cover these scenarios (IMG_W=IMG_H=4 unless stated):
- start, 1-cycle memory -> addresses 0,1,2,4,5,6,8,9,10 with direc 00; window_valid at (0,0).
- Continue with win_ack -> shift 01; addresses 3,7,11; window (1,0); shift 11; addresses 13,14,15; window (1,1); shift 10; addresses 4,8,12; window (0,1); done, 4 windows total.
- Hold win_ack low for 10 cycles -> window_valid stays high, no mem_req and no start_shift occur.
- Random mem_rvalid latency of 1-8 cycles plus stray mem_rvalid pulses in non-WAIT states -> same address and data sequence as the 1-cycle case.
- rst pulsed during COL_WAIT -> all outputs 0; a new start reproduces the full sequence from address 0.
- IMG_W=IMG_H=3 -> 9 reads, one window, done, with no start_shift.

Source files
------------

// File: rtl/window_scan_ctrl.sv
// Serpentine 3x3 window scanner: fetches pixels one read at a time and feeds
// a shifting window buffer, handing each completed window to the Sobel stage.
module window_scan_ctrl #(
   parameter int IMG_W   = 16,
   parameter int IMG_H   = 16,
   parameter int ADDR_W  = 16,
   parameter int COORD_W = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   output logic               mem_req,
   output logic [ADDR_W-1:0]  mem_addr,
   input  logic               mem_rvalid,
   input  logic [7:0]         mem_rdata,
   output logic               start_read,
   output logic               start_shift,
   output logic [1:0]         shift_direc,
   output logic [7:0]         data_r,
   input  logic               shift_done,
   output logic               window_valid,
   input  logic               win_ack,
   output logic [COORD_W-1:0] win_x,
   output logic [COORD_W-1:0] win_y,
   output logic               busy,
   output logic               done
);

   typedef enum logic [2:0] {
      IDLE, LOAD_REQ, LOAD_WAIT, EMIT, SHIFT, COL_REQ, COL_WAIT, FINISH
   } state_t;

   localparam logic [COORD_W-1:0] X_LAST = COORD_W'(IMG_W - 3);
   localparam logic [COORD_W-1:0] Y_LAST = COORD_W'(IMG_H - 3);

   localparam logic [1:0] DIR_LOAD  = 2'b00;
   localparam logic [1:0] DIR_LEFT  = 2'b01;
   localparam logic [1:0] DIR_RIGHT = 2'b10;
   localparam logic [1:0] DIR_DOWN  = 2'b11;

   state_t state, next_state;

   logic [3:0]        cnt;
   logic              dir_right;
   logic [1:0]        col_off, row_off;
   logic              last_read;
   logic              band_end, last_band;
   logic [ADDR_W-1:0] row_abs, col_abs;

   // Pixel offset inside the window for the read numbered cnt of the current group
   always_comb begin
      col_off   = 2'd0;
      row_off   = 2'd0;
      last_read = 1'b0;
      case (shift_direc)
         DIR_LOAD: begin
            last_read = (cnt == 4'd8);
            if (cnt < 4'd3) begin
               col_off = cnt[1:0];
            end else if (cnt < 4'd6) begin
               col_off = 2'(cnt - 4'd3);
               row_off = 2'd1;
            end else begin
               col_off = 2'(cnt - 4'd6);
               row_off = 2'd2;
            end
         end
         DIR_LEFT: begin
            col_off   = 2'd2;
            row_off   = cnt[1:0];
            last_read = (cnt == 4'd2);
         end
         DIR_RIGHT: begin
            row_off   = cnt[1:0];
            last_read = (cnt == 4'd2);
         end
         default: begin
            col_off   = cnt[1:0];
            row_off   = 2'd2;
            last_read = (cnt == 4'd2);
         end
      endcase
   end

   assign row_abs   = ADDR_W'(win_y) + ADDR_W'(row_off);
   assign col_abs   = ADDR_W'(win_x) + ADDR_W'(col_off);
   assign mem_addr  = mem_req ? (row_abs * ADDR_W'(IMG_W) + col_abs) : '0;

   assign band_end  = dir_right ? (win_x == X_LAST) : (win_x == '0);
   assign last_band = (win_y == Y_LAST);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= next_state;
   end

   always_comb begin
      next_state   = state;
      mem_req      = 1'b0;
      window_valid = 1'b0;
      done         = 1'b0;
      busy         = 1'b1;
      case (state)
         IDLE: begin
            busy = 1'b0;
            if (start) next_state = LOAD_REQ;
         end
         LOAD_REQ: begin
            mem_req    = 1'b1;
            next_state = LOAD_WAIT;
         end
         LOAD_WAIT: begin
            if (mem_rvalid) next_state = last_read ? EMIT : LOAD_REQ;
         end
         EMIT: begin
            window_valid = 1'b1;
            if (win_ack) next_state = (band_end && last_band) ? FINISH : SHIFT;
         end
         SHIFT: begin
            if (shift_done) next_state = COL_REQ;
         end
         COL_REQ: begin
            mem_req    = 1'b1;
            next_state = COL_WAIT;
         end
         COL_WAIT: begin
            if (mem_rvalid) next_state = last_read ? EMIT : COL_REQ;
         end
         FINISH: begin
            done       = 1'b1;
            busy       = 1'b0;
            next_state = IDLE;
         end
         default: begin
            busy       = 1'b0;
            next_state = IDLE;
         end
      endcase
   end

   // Coordinates, read counter and window-buffer strobes
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         win_x       <= '0;
         win_y       <= '0;
         dir_right   <= 1'b1;
         cnt         <= '0;
         shift_direc <= DIR_LOAD;
         data_r      <= '0;
         start_read  <= 1'b0;
         start_shift <= 1'b0;
      end else begin
         start_read  <= 1'b0;
         start_shift <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  win_x       <= '0;
                  win_y       <= '0;
                  dir_right   <= 1'b1;
                  cnt         <= '0;
                  shift_direc <= DIR_LOAD;
               end
            end
            LOAD_WAIT, COL_WAIT: begin
               if (mem_rvalid) begin
                  data_r     <= mem_rdata;
                  start_read <= 1'b1;
                  cnt        <= last_read ? 4'd0 : cnt + 4'd1;
               end
            end
            EMIT: begin
               if (win_ack && !(band_end && last_band)) begin
                  start_shift <= 1'b1;
                  if (band_end)       shift_direc <= DIR_DOWN;
                  else if (dir_right) shift_direc <= DIR_LEFT;
                  else                shift_direc <= DIR_RIGHT;
               end
            end
            SHIFT: begin
               if (shift_done) begin
                  case (shift_direc)
                     DIR_LEFT:  win_x <= win_x + 1'b1;
                     DIR_RIGHT: win_x <= win_x - 1'b1;
                     DIR_DOWN: begin
                        win_y     <= win_y + 1'b1;
                        dir_right <= ~dir_right;
                     end
                     default: ;
                  endcase
               end
            end
            FINISH: begin
               shift_direc <= DIR_LOAD;
            end
            default: ;
         endcase
      end
   end

endmodule
